// File: rtl/hamming74_pkg.sv
// Shared Hamming(7,4) constants, types and the syndrome helper used by the decoder
// and the encoder-side checker.
package hamming74_pkg;

    localparam int CW_W   = 7;
    localparam int DATA_W = 4;
    localparam int SYN_W  = 3;

    // Codeword bit i carries Hamming position i+1.
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int D0_IDX = 2;
    localparam int P4_IDX = 3;
    localparam int D1_IDX = 4;
    localparam int D2_IDX = 5;
    localparam int D3_IDX = 6;

    typedef logic [CW_W-1:0]   cw_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYN_W-1:0]  syn_t;

    function automatic syn_t calcSyndrome(input cw_t cw);
        syn_t s;
        s[0] = cw[P1_IDX] ^ cw[D0_IDX] ^ cw[D1_IDX] ^ cw[D3_IDX];
        s[1] = cw[P2_IDX] ^ cw[D0_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        s[2] = cw[P4_IDX] ^ cw[D1_IDX] ^ cw[D2_IDX] ^ cw[D3_IDX];
        return s;
    endfunction

    function automatic data_t extractData(input cw_t cw);
        return {cw[D3_IDX], cw[D2_IDX], cw[D1_IDX], cw[D0_IDX]};
    endfunction

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome generator; a nonzero result names the
// 1-based position of a single flipped bit.
module hamming74_syndrome
    import hamming74_pkg::*;
(
    input  logic [CW_W-1:0]  i_cw,
    output logic [SYN_W-1:0] o_syn
);

    assign o_syn = calcSyndrome(i_cw);

endmodule

// File: rtl/hamming74_correct_pipe.sv
// Two-stage streaming Hamming(7,4) single-error-correcting decoder with
// valid/ready flow control and saturating delivery statistics.
module hamming74_correct_pipe
    import hamming74_pkg::*;
#(
    parameter int CNT_W = 16
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CW_W-1:0]   in_cw,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic [SYN_W-1:0]  out_syn,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cw_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    logic               w_en1;
    logic               w_en2;
    logic               w_xfer;
    logic [SYN_W-1:0]   w_syn;
    logic [CW_W-1:0]    w_flipMask;
    logic [CW_W-1:0]    w_corrCw;

    logic               r_v1;
    logic [CW_W-1:0]    r_cw1;
    logic [SYN_W-1:0]   r_syn1;

    logic               r_v2;
    logic [DATA_W-1:0]  r_data2;
    logic               r_err2;
    logic [SYN_W-1:0]   r_syn2;

    logic [CNT_W-1:0]   r_cwCnt;
    logic [CNT_W-1:0]   r_errCnt;

    // A stage may load when it is empty or its downstream is moving this cycle.
    assign w_en2    = !r_v2 || out_ready;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;
    assign w_xfer   = r_v2 && out_ready;

    hamming74_syndrome u_syndrome (
        .i_cw  (in_cw),
        .o_syn (w_syn)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1   <= 1'b0;
            r_cw1  <= '0;
            r_syn1 <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_cw1  <= in_cw;
                r_syn1 <= w_syn;
            end
        end
    end

    // Syndrome k flips bit k-1; parity-bit flips leave the data untouched.
    always_comb begin
        w_flipMask = '0;
        if (r_syn1 != '0) begin
            w_flipMask = {{(CW_W-1){1'b0}}, 1'b1} << (r_syn1 - 3'd1);
        end
        w_corrCw = r_cw1 ^ w_flipMask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2    <= 1'b0;
            r_data2 <= '0;
            r_err2  <= 1'b0;
            r_syn2  <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_data2 <= extractData(w_corrCw);
                r_err2  <= (r_syn1 != '0);
                r_syn2  <= r_syn1;
            end
        end
    end

    // Clear wins over a same-cycle delivery; both counters stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cwCnt  <= '0;
            r_errCnt <= '0;
        end else if (cnt_clr) begin
            r_cwCnt  <= '0;
            r_errCnt <= '0;
        end else if (w_xfer) begin
            if (r_cwCnt != {CNT_W{1'b1}}) begin
                r_cwCnt <= r_cwCnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (r_err2 && (r_errCnt != {CNT_W{1'b1}})) begin
                r_errCnt <= r_errCnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign out_valid = r_v2;
    assign out_data  = r_data2;
    assign out_err   = r_err2;
    assign out_syn   = r_syn2;
    assign cw_cnt    = r_cwCnt;
    assign err_cnt   = r_errCnt;

endmodule

// File: tb/tb_hamming74_correct_pipe.sv
// Self-checking bench for hamming74_correct_pipe: a nearest-codeword model with a
// per-cycle compare process, plus directed vectors with literal expectations.
module tb_hamming74_correct_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [6:0]  in_cw;
    logic        out_ready;
    logic        cnt_clr;

    logic        in_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic        out_err;
    logic [2:0]  out_syn;
    logic [15:0] cw_cnt;
    logic [15:0] err_cnt;

    logic        satInReady;
    logic        satOutValid;
    logic [3:0]  satOutData;
    logic        satOutErr;
    logic [2:0]  satOutSyn;
    logic [1:0]  satCwCnt;
    logic [1:0]  satErrCnt;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic [2:0] syn;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   m16Cw  = 0;
    int   m16Err = 0;
    int   m2Cw   = 0;
    int   m2Err  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    hamming74_correct_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cw     (in_cw),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_syn   (out_syn),
        .cnt_clr   (cnt_clr),
        .cw_cnt    (cw_cnt),
        .err_cnt   (err_cnt)
    );

    hamming74_correct_pipe #(.CNT_W(2)) dutSat (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (satInReady),
        .in_cw     (in_cw),
        .out_valid (satOutValid),
        .out_ready (out_ready),
        .out_data  (satOutData),
        .out_err   (satOutErr),
        .out_syn   (satOutSyn),
        .cnt_clr   (cnt_clr),
        .cw_cnt    (satCwCnt),
        .err_cnt   (satErrCnt)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Textbook encoder: p1 covers positions 3,5,7; p2 covers 3,6,7; p4 covers 5,6,7.
    function automatic logic [6:0] encodeWord(input logic [3:0] d);
        logic [6:0] c;
        c[0] = d[0] ^ d[1] ^ d[3];
        c[1] = d[0] ^ d[2] ^ d[3];
        c[2] = d[0];
        c[3] = d[1] ^ d[2] ^ d[3];
        c[4] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        return c;
    endfunction

    // Nearest-codeword search: find the data value and single flip position that explain cw.
    function automatic exp_t decodeModel(input logic [6:0] cw);
        exp_t r;
        r.data = 4'd0;
        r.err  = 1'b0;
        r.syn  = 3'd0;
        r.acc  = 0;
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                logic [6:0] cand;
                cand = encodeWord(4'(d));
                if (e < 7) cand[e] = ~cand[e];
                if (cand == cw) begin
                    r.data = 4'(d);
                    r.err  = (e < 7);
                    r.syn  = (e < 7) ? 3'(e + 1) : 3'd0;
                end
            end
        end
        return r;
    endfunction

    // Per-cycle comparison against the model, then advance the model for this edge.
    always @(negedge clk) begin : cmpBlk
        logic expValid;
        logic expReady;
        exp_t e;
        if (!rst_n) begin
            q.delete();
            m16Cw = 0; m16Err = 0; m2Cw = 0; m2Err = 0;
            checkOutput("rst_out_valid", 32'(out_valid), 0);
            checkOutput("rst_in_ready", 32'(in_ready), 1);
            checkOutput("rst_out_data", 32'(out_data), 0);
            checkOutput("rst_cw_cnt", 32'(cw_cnt), 0);
            checkOutput("rst_err_cnt", 32'(err_cnt), 0);
            checkOutput("rst_sat_cw_cnt", 32'(satCwCnt), 0);
        end else begin
            expValid = 1'b0;
            if (q.size() > 0) begin
                if (cycle - q[0].acc >= 2) expValid = 1'b1;
            end
            expReady = !(q.size() >= 2 && !out_ready);

            checkOutput("out_valid", 32'(out_valid), 32'(expValid));
            checkOutput("sat_out_valid", 32'(satOutValid), 32'(expValid));
            checkOutput("in_ready", 32'(in_ready), 32'(expReady));
            checkOutput("sat_in_ready", 32'(satInReady), 32'(expReady));
            if (expValid) begin
                e = q[0];
                checkOutput("out_data", 32'(out_data), 32'(e.data));
                checkOutput("out_err", 32'(out_err), 32'(e.err));
                checkOutput("out_syn", 32'(out_syn), 32'(e.syn));
                checkOutput("sat_out_data", 32'(satOutData), 32'(e.data));
                checkOutput("sat_out_err", 32'(satOutErr), 32'(e.err));
                checkOutput("sat_out_syn", 32'(satOutSyn), 32'(e.syn));
            end
            checkOutput("cw_cnt", 32'(cw_cnt), 32'(m16Cw));
            checkOutput("err_cnt", 32'(err_cnt), 32'(m16Err));
            checkOutput("sat_cw_cnt", 32'(satCwCnt), 32'(m2Cw));
            checkOutput("sat_err_cnt", 32'(satErrCnt), 32'(m2Err));

            if (cnt_clr) begin
                m16Cw = 0; m16Err = 0; m2Cw = 0; m2Err = 0;
            end
            if (expValid && out_ready) begin
                e = q.pop_front();
                if (!cnt_clr) begin
                    if (m16Cw < 65535) m16Cw++;
                    if (m2Cw < 3) m2Cw++;
                    if (e.err && m16Err < 65535) m16Err++;
                    if (e.err && m2Err < 3) m2Err++;
                end
            end
            if (in_valid && expReady) begin
                e = decodeModel(in_cw);
                e.acc = cycle;
                q.push_back(e);
            end
        end
    end

    // Present one word for one cycle; caller is just after a rising edge.
    task automatic applyStimulus(input logic [6:0] cw);
        in_valid = 1'b1;
        in_cw    = cw;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        in_cw    = 7'($urandom);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitOut(input string name);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_timeout"}, 32'(out_valid), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_cw     = 7'd0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Clean word 1011 -> 0x55
        applyStimulus(7'h55);
        in_valid = 1'b0;
        waitOut("clean");
        checkOutput("clean_data", 32'(out_data), 32'h0B);
        checkOutput("clean_err", 32'(out_err), 0);
        checkOutput("clean_syn", 32'(out_syn), 0);
        @(negedge clk);
        checkOutput("clean_cw_cnt", 32'(cw_cnt), 1);
        checkOutput("clean_err_cnt", 32'(err_cnt), 0);
        @(posedge clk);
        #1;

        // Bit 4 flipped -> syndrome 5
        applyStimulus(7'h45);
        in_valid = 1'b0;
        waitOut("single");
        checkOutput("single_data", 32'(out_data), 32'h0B);
        checkOutput("single_err", 32'(out_err), 1);
        checkOutput("single_syn", 32'(out_syn), 5);
        @(negedge clk);
        checkOutput("single_cw_cnt", 32'(cw_cnt), 2);
        checkOutput("single_err_cnt", 32'(err_cnt), 1);
        @(posedge clk);
        #1;

        // Back-to-back sweep of all data values and flip positions (7 = none)
        for (int d = 0; d < 16; d++) begin
            for (int e = 0; e < 8; e++) begin
                logic [6:0] w;
                w = encodeWord(4'(d));
                if (e < 7) w[e] = ~w[e];
                checkOutput("sweep_in_ready", 32'(in_ready), 1);
                applyStimulus(w);
            end
        end
        idleCycles(4);
        checkOutput("sweep_cw_cnt", 32'(cw_cnt), 130);
        checkOutput("sweep_err_cnt", 32'(err_cnt), 113);
        checkOutput("sweep_sat_cw_cnt", 32'(satCwCnt), 3);
        checkOutput("sweep_sat_err_cnt", 32'(satErrCnt), 3);

        // Backpressure: two words fill the pipe, third must wait
        out_ready = 1'b0;
        applyStimulus(encodeWord(4'h3));
        applyStimulus(encodeWord(4'hC) ^ 7'h01);
        in_cw = encodeWord(4'h9) ^ 7'h40;
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_in_ready", 32'(in_ready), 0);
            checkOutput("bp_out_valid", 32'(out_valid), 1);
            checkOutput("bp_out_data", 32'(out_data), 32'h3);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        idleCycles(5);
        checkOutput("bp_cw_cnt", 32'(cw_cnt), 133);
        checkOutput("bp_err_cnt", 32'(err_cnt), 115);

        // Clear coinciding with a delivery
        applyStimulus(encodeWord(4'h6));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr_xfer_valid", 32'(out_valid), 1);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        checkOutput("clr_cw_cnt", 32'(cw_cnt), 0);
        checkOutput("clr_err_cnt", 32'(err_cnt), 0);
        checkOutput("clr_sat_cw_cnt", 32'(satCwCnt), 0);
        applyStimulus(encodeWord(4'hA) ^ 7'h04);
        idleCycles(4);
        checkOutput("after_clr_cw_cnt", 32'(cw_cnt), 1);
        checkOutput("after_clr_err_cnt", 32'(err_cnt), 1);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        applyStimulus(encodeWord(4'h5));
        applyStimulus(encodeWord(4'hE));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_valid", 32'(out_valid), 0);
        checkOutput("arst_cw_cnt", 32'(cw_cnt), 0);
        checkOutput("arst_err_cnt", 32'(err_cnt), 0);
        checkOutput("arst_in_ready", 32'(in_ready), 1);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idleCycles(6);
        checkOutput("post_rst_in_ready", 32'(in_ready), 1);
        checkOutput("post_rst_out_valid", 32'(out_valid), 0);
        checkOutput("post_rst_cw_cnt", 32'(cw_cnt), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
